// File: rtl/cordic_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_mux_arbiter
//  Purpose  : Round-robin arbiter that shares one fixed-latency CORDIC
//             add/sub datapath among three requesters. It drives the select
//             of the upstream 3:1 operand mux, follows every issued operation
//             through the shared unit, and returns a done pulse to the owner.
//             A requester may keep the unit for a bounded burst of
//             back-to-back iterations.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LAT          latency of the shared unit, grant cycle to result cycle (>=1)
//    MAX_BURST    max consecutive grants one owner may hold while others wait
//  Ports
//    clk          clock, rising edge
//    rst          synchronous reset, active-high (dominates everything)
//    req_i[3]     requester i has an operand waiting on mux channel ch_i
//    hold_i[3]    current owner asks to keep the grant next cycle
//    flush_i      drop every in-flight operation and the pending grant
//    sel_mux_o[2] operand mux select: 00=zero, 01=ch_0, 10=ch_1, 11=ch_2
//    grant_o[3]   one-hot grant, grant_o[i] <=> sel_mux_o == i+1
//    unit_valid_o shared unit consumes a valid operand this cycle
//    done_o[3]    one-hot pulse: result for requester i is on the unit output
//    busy_o       unit_valid_o or any operation still in flight
// ============================================================================
module cordic_mux_arbiter #(
    parameter int LAT       = 2,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic [2:0] hold_i,
    input  logic       flush_i,
    output logic [1:0] sel_mux_o,
    output logic [2:0] grant_o,
    output logic       unit_valid_o,
    output logic [2:0] done_o,
    output logic       busy_o
);

    // burst_cnt counts extra grants beyond the first, so it tops out at
    // MAX_BURST-1.
    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);

    logic [1:0]       sel_q,       sel_d;
    logic [2:0]       grant_q,     grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       last_q,      last_d;

    // Tag pipeline: mux codes of issued operations, oldest at index LAT-1.
    logic [1:0]       tag_q [LAT];

    logic [1:0]       scan [3];
    logic             rr_found;
    logic [1:0]       rr_idx;
    logic             burst_keep;

    // grant_q is one-hot, so the AND picks out the owner's req/hold bits.
    assign burst_keep = (|(grant_q & req_i & hold_i)) && (burst_cnt_q < BURST_LIM);

    // Round-robin search order starts just after the last winner.
    always_comb begin
        case (last_q)
            2'd0: begin
                scan[0] = 2'd1;
                scan[1] = 2'd2;
                scan[2] = 2'd0;
            end
            2'd1: begin
                scan[0] = 2'd2;
                scan[1] = 2'd0;
                scan[2] = 2'd1;
            end
            default: begin
                scan[0] = 2'd0;
                scan[1] = 2'd1;
                scan[2] = 2'd2;
            end
        endcase

        rr_found = 1'b0;
        rr_idx   = 2'd0;
        // Walk from lowest to highest priority so the highest one wins.
        for (int k = 2; k >= 0; k--) begin
            if (req_i[scan[k]]) begin
                rr_found = 1'b1;
                rr_idx   = scan[k];
            end
        end
    end

    // Next grant decision. The previous owner sits last in the scan order, so
    // a round-robin win by the same owner only happens when nobody else asks;
    // every round-robin win therefore restarts the burst count.
    always_comb begin
        sel_d       = 2'b00;
        grant_d     = 3'b000;
        burst_cnt_d = '0;
        last_d      = last_q;

        if (flush_i) begin
            // Idle for one cycle; last pointer is kept.
        end else if (burst_keep) begin
            sel_d       = sel_q;
            grant_d     = grant_q;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else if (rr_found) begin
            sel_d   = rr_idx + 2'd1;
            grant_d = 3'b001 << rr_idx;
            last_d  = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 2'b00;
            grant_q     <= 3'b000;
            burst_cnt_q <= '0;
            last_q      <= 2'd2;
        end else begin
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end

    // The code granted in cycle c enters stage 0 at the end of c and reaches
    // stage LAT-1 in cycle c+LAT, which is when its result leaves the unit.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= 2'b00;
            end
        end else begin
            tag_q[0] <= sel_q;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign sel_mux_o    = sel_q;
    assign grant_o      = grant_q;
    assign unit_valid_o = |sel_q;

    always_comb begin
        done_o = 3'b000;
        case (tag_q[LAT-1])
            2'b01:   done_o = 3'b001;
            2'b10:   done_o = 3'b010;
            2'b11:   done_o = 3'b100;
            default: done_o = 3'b000;
        endcase
    end

    always_comb begin
        busy_o = |sel_q;
        for (int i = 0; i < LAT; i++) begin
            busy_o = busy_o | (|tag_q[i]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_mux_arbiter
//  Purpose  : Directed self-checking bench for cordic_mux_arbiter (LAT=2,
//             MAX_BURST=4). Each scenario is a per-cycle table of inputs
//             {rst, flush, req[2:0], hold[2:0]} and hand-computed outputs
//             {grant[2:0], done[2:0], busy}; sel_mux and unit_valid follow
//             from the expected grant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] hold;
    logic       flush;
    logic [1:0] sel_mux;
    logic [2:0] grant;
    logic       unit_valid;
    logic [2:0] done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    cordic_mux_arbiter #(
        .LAT       (2),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .hold_i       (hold),
        .flush_i      (flush),
        .sel_mux_o    (sel_mux),
        .grant_o      (grant),
        .unit_valid_o (unit_valid),
        .done_o       (done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [9:0] exp_v;
        logic [9:0] obs;
        // Plain reset.
        rst = 1'b1; flush = 1'b0; req = 3'b000; hold = 3'b000;
        @(posedge clk); #1;
        exp_v = 10'b0;
        obs   = {sel_mux, grant, unit_valid, done, busy};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset: got sel/grant/uv/done/busy=%b expected %b", obs, exp_v);
        end
        // Reset dominates flush and requests.
        rst = 1'b1; flush = 1'b1; req = 3'b111; hold = 3'b111;
        @(posedge clk); #1;
        obs = {sel_mux, grant, unit_valid, done, busy};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_dominates: got sel/grant/uv/done/busy=%b expected %b", obs, exp_v);
        end
        rst = 1'b0; flush = 1'b0; req = 3'b000; hold = 3'b000;
    endtask

    // req=111, hold=000: rotation 0,1,2,0,1,2 then drain.
    task automatic test_round_robin();
        logic [7:0] stim [9] = '{8'b0_0_111_000, 8'b0_0_111_000, 8'b0_0_111_000,
                                 8'b0_0_111_000, 8'b0_0_111_000, 8'b0_0_111_000,
                                 8'b0_0_000_000, 8'b0_0_000_000, 8'b0_0_000_000};
        logic [6:0] expv [9] = '{7'b001_000_1, 7'b010_000_1, 7'b100_001_1,
                                 7'b001_010_1, 7'b010_100_1, 7'b100_001_1,
                                 7'b000_010_1, 7'b000_100_1, 7'b000_000_0};
        for (int k = 0; k < 9; k++) begin
            logic [1:0] es;
            {rst, flush, req, hold} = stim[k];
            @(posedge clk); #1;
            es = expv[k][6] ? 2'd3 : expv[k][5] ? 2'd2 : expv[k][4] ? 2'd1 : 2'd0;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== {es, expv[k][6:4], |expv[k][6:4], expv[k][3:0]}) begin
                errors++;
                $display("FAIL round_robin cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected sel=%b grant=%b done=%b busy=%b",
                         k, sel_mux, grant, unit_valid, done, busy, es, expv[k][6:4], expv[k][3:1], expv[k][0]);
            end
        end
    endtask

    // Lone requester ch_1 for four cycles, then drain.
    task automatic test_single_requester();
        logic [7:0] stim [7] = '{8'b0_0_010_000, 8'b0_0_010_000, 8'b0_0_010_000,
                                 8'b0_0_010_000, 8'b0_0_000_000, 8'b0_0_000_000,
                                 8'b0_0_000_000};
        logic [6:0] expv [7] = '{7'b010_000_1, 7'b010_000_1, 7'b010_010_1,
                                 7'b010_010_1, 7'b000_010_1, 7'b000_010_1,
                                 7'b000_000_0};
        for (int k = 0; k < 7; k++) begin
            logic [1:0] es;
            {rst, flush, req, hold} = stim[k];
            @(posedge clk); #1;
            es = expv[k][6] ? 2'd3 : expv[k][5] ? 2'd2 : expv[k][4] ? 2'd1 : 2'd0;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== {es, expv[k][6:4], |expv[k][6:4], expv[k][3:0]}) begin
                errors++;
                $display("FAIL single_req cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected sel=%b grant=%b done=%b busy=%b",
                         k, sel_mux, grant, unit_valid, done, busy, es, expv[k][6:4], expv[k][3:1], expv[k][0]);
            end
        end
    endtask

    // Reset, then req=111 hold=001: ch_0 x4, ch_1, ch_2, ch_0, ch_0, then drain.
    task automatic test_burst();
        logic [7:0] stim [12] = '{8'b1_0_000_000,
                                  8'b0_0_111_001, 8'b0_0_111_001, 8'b0_0_111_001,
                                  8'b0_0_111_001, 8'b0_0_111_001, 8'b0_0_111_001,
                                  8'b0_0_111_001, 8'b0_0_111_001, 8'b0_0_000_000,
                                  8'b0_0_000_000, 8'b0_0_000_000};
        logic [6:0] expv [12] = '{7'b000_000_0,
                                  7'b001_000_1, 7'b001_000_1, 7'b001_001_1,
                                  7'b001_001_1, 7'b010_001_1, 7'b100_001_1,
                                  7'b001_010_1, 7'b001_100_1, 7'b000_001_1,
                                  7'b000_001_1, 7'b000_000_0};
        for (int k = 0; k < 12; k++) begin
            logic [1:0] es;
            {rst, flush, req, hold} = stim[k];
            @(posedge clk); #1;
            es = expv[k][6] ? 2'd3 : expv[k][5] ? 2'd2 : expv[k][4] ? 2'd1 : 2'd0;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== {es, expv[k][6:4], |expv[k][6:4], expv[k][3:0]}) begin
                errors++;
                $display("FAIL burst cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected sel=%b grant=%b done=%b busy=%b",
                         k, sel_mux, grant, unit_valid, done, busy, es, expv[k][6:4], expv[k][3:1], expv[k][0]);
            end
        end
    endtask

    // Reset, grant ch_0 then ch_1, flush: no done for either, idle one
    // cycle, then arbitration resumes at ch_2.
    task automatic test_flush();
        logic [7:0] stim [10] = '{8'b1_0_000_000,
                                  8'b0_0_111_000, 8'b0_0_111_000, 8'b0_1_111_000,
                                  8'b0_0_111_000, 8'b0_0_111_000, 8'b0_0_111_000,
                                  8'b0_0_000_000, 8'b0_0_000_000, 8'b0_0_000_000};
        logic [6:0] expv [10] = '{7'b000_000_0,
                                  7'b001_000_1, 7'b010_000_1, 7'b000_000_0,
                                  7'b100_000_1, 7'b001_000_1, 7'b010_100_1,
                                  7'b000_001_1, 7'b000_010_1, 7'b000_000_0};
        for (int k = 0; k < 10; k++) begin
            logic [1:0] es;
            {rst, flush, req, hold} = stim[k];
            @(posedge clk); #1;
            es = expv[k][6] ? 2'd3 : expv[k][5] ? 2'd2 : expv[k][4] ? 2'd1 : 2'd0;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== {es, expv[k][6:4], |expv[k][6:4], expv[k][3:0]}) begin
                errors++;
                $display("FAIL flush cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected sel=%b grant=%b done=%b busy=%b",
                         k, sel_mux, grant, unit_valid, done, busy, es, expv[k][6:4], expv[k][3:1], expv[k][0]);
            end
        end
    endtask

    // Reset while ch_0 bursts with two ops in flight; afterwards ch_0 wins first.
    task automatic test_reset_mid_burst();
        logic [7:0] stim [10] = '{8'b1_0_000_000,
                                  8'b0_0_111_001, 8'b0_0_111_001, 8'b0_0_111_001,
                                  8'b1_0_111_001, 8'b0_0_111_000, 8'b0_0_111_000,
                                  8'b0_0_000_000, 8'b0_0_000_000, 8'b0_0_000_000};
        logic [6:0] expv [10] = '{7'b000_000_0,
                                  7'b001_000_1, 7'b001_000_1, 7'b001_001_1,
                                  7'b000_000_0, 7'b001_000_1, 7'b010_000_1,
                                  7'b000_001_1, 7'b000_010_1, 7'b000_000_0};
        for (int k = 0; k < 10; k++) begin
            logic [1:0] es;
            {rst, flush, req, hold} = stim[k];
            @(posedge clk); #1;
            es = expv[k][6] ? 2'd3 : expv[k][5] ? 2'd2 : expv[k][4] ? 2'd1 : 2'd0;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== {es, expv[k][6:4], |expv[k][6:4], expv[k][3:0]}) begin
                errors++;
                $display("FAIL reset_mid_burst cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected sel=%b grant=%b done=%b busy=%b",
                         k, sel_mux, grant, unit_valid, done, busy, es, expv[k][6:4], expv[k][3:1], expv[k][0]);
            end
        end
    endtask

    // No requests: mux drives zero, nothing valid, nothing in flight.
    task automatic test_idle();
        for (int k = 0; k < 3; k++) begin
            rst = 1'b0; flush = 1'b0; req = 3'b000; hold = 3'b000;
            @(posedge clk); #1;
            checks++;
            if ({sel_mux, grant, unit_valid, done, busy} !== 10'b0) begin
                errors++;
                $display("FAIL idle cyc %0d: got sel=%b grant=%b uv=%b done=%b busy=%b expected all zero",
                         k, sel_mux, grant, unit_valid, done, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req = 3'b000; hold = 3'b000;
        test_reset();
        test_round_robin();
        test_single_requester();
        test_burst();
        test_flush();
        test_reset_mid_burst();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
